// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core
// load/store path and the host preload/readback port.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ARB       = 2'd0,
        HOST_LOCK = 2'd1,
        CORE_SLOT = 2'd2
    } arbState_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_HOST = 2'd2
    } owner_e;

    localparam int DEF_STARVE_LIM = 4;
    localparam int DEF_LOCK_MAX   = 16;

    // Normal arbitration: core wins unless the host has waited long enough
    // to earn a single forced access.
    function automatic owner_e arbPick(input logic coreReq,
                                       input logic hostReq,
                                       input logic starveHit);
        owner_e pick;
        pick = OWN_NONE;
        if (coreReq && !(hostReq && starveHit)) begin
            pick = OWN_CORE;
        end else if (hostReq) begin
            pick = OWN_HOST;
        end
        return pick;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with clear priority, used for the host starvation
// count and the locked-burst length count.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int LIMIT = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Inc,
    input  logic             Clr,
    output logic [WIDTH-1:0] Count,
    output logic             AtLim
);

    localparam logic [WIDTH-1:0] LimVal = WIDTH'(LIMIT);

    // Count up on Inc, hold at the limit, clear takes precedence over Inc.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= '0;
        end else if (Inc && (Count != LimVal)) begin
            Count <= Count + WIDTH'(1);
        end
    end

    assign AtLim = (Count == LimVal);

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: core has default priority, the host is
// served on idle core cycles, after a starvation limit, or in a bounded
// locked burst that always ends with one reserved core slot.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = 8,
    parameter int DW         = 8,
    parameter int STARVE_LIM = DEF_STARVE_LIM,
    parameter int LOCK_MAX   = DEF_LOCK_MAX
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CoreReq,
    input  logic          CoreWe,
    input  logic [AW-1:0] CoreAddr,
    input  logic [DW-1:0] CoreWData,
    output logic          CoreGnt,
    output logic          CoreStall,
    output logic          CoreRValid,
    output logic [DW-1:0] CoreRData,
    input  logic          HostReq,
    input  logic          HostWe,
    input  logic          HostLock,
    input  logic [AW-1:0] HostAddr,
    input  logic [DW-1:0] HostWData,
    output logic          HostGnt,
    output logic          HostRValid,
    output logic [DW-1:0] HostRData,
    output logic [AW-1:0] MemAddr,
    output logic          MemWe,
    output logic [DW-1:0] MemWData,
    input  logic [DW-1:0] MemRData
);

    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [LW-1:0] LockLast = LW'(LOCK_MAX - 1);

    arbState_e state;
    arbState_e stateNext;
    owner_e    owner;

    logic          coreGrant;
    logic          hostGrant;
    logic          pendCore;
    logic          pendHost;

    logic          starveInc;
    logic          starveClr;
    logic          starveAtLim;
    logic [SW-1:0] starveCnt;

    logic          lockInc;
    logic          lockClr;
    logic          lockAtLim;
    logic [LW-1:0] lockCnt;

    // Only the limit flag of the starvation counter matters to arbitration;
    // the raw count is folded here so it is visibly consumed.
    logic          unusedStarveCnt;
    assign unusedStarveCnt = ^starveCnt;

    // Grant decode and next-state selection; nothing is granted in reset.
    always_comb begin
        owner     = OWN_NONE;
        stateNext = state;
        if (Reset) begin
            case (state)
                ARB: begin
                    owner = arbPick(CoreReq, HostReq, starveAtLim);
                    if ((owner == OWN_HOST) && HostLock) begin
                        stateNext = HOST_LOCK;
                    end
                end
                HOST_LOCK: begin
                    if (!HostLock) begin
                        owner     = arbPick(CoreReq, HostReq, starveAtLim);
                        stateNext = ARB;
                    end else if (lockAtLim) begin
                        stateNext = CORE_SLOT;
                    end else if (HostReq) begin
                        owner = OWN_HOST;
                        if (lockCnt == LockLast) begin
                            stateNext = CORE_SLOT;
                        end
                    end
                end
                CORE_SLOT: begin
                    if (CoreReq) begin
                        owner = OWN_CORE;
                    end
                    stateNext = ARB;
                end
                default: begin
                    stateNext = ARB;
                end
            endcase
        end
    end

    assign coreGrant = (owner == OWN_CORE);
    assign hostGrant = (owner == OWN_HOST);

    assign starveInc = HostReq & ~hostGrant;
    assign starveClr = ~starveInc;
    assign lockInc   = hostGrant & HostLock;
    assign lockClr   = (stateNext == ARB);

    sat_counter #(
        .WIDTH (SW),
        .LIMIT (STARVE_LIM)
    ) starveCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (starveInc),
        .Clr   (starveClr),
        .Count (starveCnt),
        .AtLim (starveAtLim)
    );

    sat_counter #(
        .WIDTH (LW),
        .LIMIT (LOCK_MAX)
    ) lockCounter (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (lockInc),
        .Clr   (lockClr),
        .Count (lockCnt),
        .AtLim (lockAtLim)
    );

    // Route the granted requester onto the memory port; idle port drives zeros.
    always_comb begin
        MemAddr  = '0;
        MemWe    = 1'b0;
        MemWData = '0;
        case (owner)
            OWN_CORE: begin
                MemAddr  = CoreAddr;
                MemWe    = CoreWe;
                MemWData = CoreWData;
            end
            OWN_HOST: begin
                MemAddr  = HostAddr;
                MemWe    = HostWe;
                MemWData = HostWData;
            end
            default: begin
                MemAddr  = '0;
                MemWe    = 1'b0;
                MemWData = '0;
            end
        endcase
    end

    // Arbiter state plus the per-requester read-pending flags that steer the
    // memory's one-cycle-late read data back to whoever issued the read.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= ARB;
            pendCore <= 1'b0;
            pendHost <= 1'b0;
        end else begin
            state    <= stateNext;
            pendCore <= coreGrant & ~CoreWe;
            pendHost <= hostGrant & ~HostWe;
        end
    end

    assign CoreGnt    = coreGrant;
    assign HostGnt    = hostGrant;
    assign CoreStall  = Reset & CoreReq & ~coreGrant;
    assign CoreRValid = Reset & pendCore;
    assign HostRValid = Reset & pendHost;
    assign CoreRData  = CoreRValid ? MemRData : '0;
    assign HostRData  = HostRValid ? MemRData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small registered-read memory model
// standing in for dat_mem.
module tb_dmem_arbiter;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       CoreReq = 1'b0, CoreWe = 1'b0;
    logic [7:0] CoreAddr = '0, CoreWData = '0;
    logic       CoreGnt, CoreStall, CoreRValid;
    logic [7:0] CoreRData;
    logic       HostReq = 1'b0, HostWe = 1'b0, HostLock = 1'b0;
    logic [7:0] HostAddr = '0, HostWData = '0;
    logic       HostGnt, HostRValid;
    logic [7:0] HostRData;
    logic [7:0] MemAddr, MemWData;
    logic       MemWe;
    logic [7:0] MemRData;

    logic [7:0] mem [256];

    int compared = 0;
    int mismatched = 0;

    always #5 Clk = ~Clk;

    dmem_arbiter dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .CoreReq    (CoreReq),
        .CoreWe     (CoreWe),
        .CoreAddr   (CoreAddr),
        .CoreWData  (CoreWData),
        .CoreGnt    (CoreGnt),
        .CoreStall  (CoreStall),
        .CoreRValid (CoreRValid),
        .CoreRData  (CoreRData),
        .HostReq    (HostReq),
        .HostWe     (HostWe),
        .HostLock   (HostLock),
        .HostAddr   (HostAddr),
        .HostWData  (HostWData),
        .HostGnt    (HostGnt),
        .HostRValid (HostRValid),
        .HostRData  (HostRData),
        .MemAddr    (MemAddr),
        .MemWe      (MemWe),
        .MemWData   (MemWData),
        .MemRData   (MemRData)
    );

    // Single-port memory model: write on the edge, read data one cycle later.
    always @(posedge Clk) begin
        if (MemWe) mem[MemAddr] <= MemWData;
        MemRData <= mem[MemAddr];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs just after the edge, then let comb outputs settle.
    task automatic applyStimulus(input logic rst,
                                 input logic cReq, input logic cWe,
                                 input logic [7:0] cAddr, input logic [7:0] cWd,
                                 input logic hReq, input logic hWe, input logic hLock,
                                 input logic [7:0] hAddr, input logic [7:0] hWd);
        @(posedge Clk);
        #1;
        Reset     = rst;
        CoreReq   = cReq;
        CoreWe    = cWe;
        CoreAddr  = cAddr;
        CoreWData = cWd;
        HostReq   = hReq;
        HostWe    = hWe;
        HostLock  = hLock;
        HostAddr  = hAddr;
        HostWData = hWd;
        #2;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hostIdx, coreGnts, coreAt, cyc;
        logic coreWant, coreSeen, prevCore;

        // Reset held with every request active.
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h30, 8'h77, 1'b1, 1'b0, 1'b1, 8'h20, 8'h00);
        checkOutput("rstCoreGnt", CoreGnt, 0);
        checkOutput("rstHostGnt", HostGnt, 0);
        checkOutput("rstMemWe", MemWe, 0);
        checkOutput("rstCoreRValid", CoreRValid, 0);
        checkOutput("rstHostRValid", HostRValid, 0);
        checkOutput("rstCoreStall", CoreStall, 0);

        // First cycle out of reset: core wins against the host.
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h30, 8'h77, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        checkOutput("relCoreGnt", CoreGnt, 1);
        checkOutput("relHostGnt", HostGnt, 0);
        checkOutput("relMemAddr", MemAddr, 8'h30);
        checkOutput("relMemWe", MemWe, 1);

        // Host preload 0x10 = 0xA5 on an idle core cycle.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h10, 8'hA5);
        checkOutput("preHostGnt", HostGnt, 1);
        checkOutput("preMemWData", MemWData, 8'hA5);
        idleCycle();

        // Core read of 0x10.
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("crdGnt", CoreGnt, 1);
        checkOutput("crdMemAddr", MemAddr, 8'h10);
        checkOutput("crdMemWe", MemWe, 0);
        idleCycle();
        checkOutput("crdRValid", CoreRValid, 1);
        checkOutput("crdRData", CoreRData, 8'hA5);
        checkOutput("crdHostRValid", HostRValid, 0);
        idleCycle();
        checkOutput("crdRValidDone", CoreRValid, 0);

        // Host write then read of 0x20, back to back.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h20, 8'h3C);
        checkOutput("hwrGnt", HostGnt, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
        checkOutput("hrdGnt", HostGnt, 1);
        checkOutput("hwrNoRValid", HostRValid, 0);
        idleCycle();
        checkOutput("hrdRValid", HostRValid, 1);
        checkOutput("hrdRData", HostRData, 8'h3C);
        checkOutput("hrdNoCoreRValid", CoreRValid, 0);
        idleCycle();

        // Both request every cycle: the host is force-granted on the fifth.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 8'(8'h40 + i), 8'(i), 1'b1, 1'b0, 1'b0, 8'h20, 8'h00);
            checkOutput($sformatf("stvCoreGnt%0d", i), CoreGnt, (i != 5));
            checkOutput($sformatf("stvHostGnt%0d", i), HostGnt, (i == 5));
            checkOutput($sformatf("stvCoreStall%0d", i), CoreStall, (i == 5));
            if (i == 6) begin
                checkOutput("stvHostRValid", HostRValid, 1);
                checkOutput("stvHostRData", HostRData, 8'h3C);
            end
        end
        idleCycle();

        // Locked host burst of 20 writes; core asks once the lock is held.
        hostIdx  = 0;
        coreGnts = 0;
        coreAt   = -1;
        cyc      = 0;
        coreWant = 1'b0;
        coreSeen = 1'b0;
        prevCore = 1'b0;
        while (hostIdx < 20 && cyc < 60) begin
            applyStimulus(1'b1, coreWant, 1'b0, 8'h30, 8'h00,
                          1'b1, 1'b1, 1'b1, 8'(hostIdx), 8'(8'h80 + hostIdx));
            cyc++;
            if (prevCore) begin
                checkOutput("lockCoreRValid", CoreRValid, 1);
                checkOutput("lockCoreRData", CoreRData, 8'h77);
            end
            prevCore = CoreGnt;
            if (cyc == 2) checkOutput("lockCoreStall", CoreStall, 1);
            if (CoreGnt && HostGnt) checkOutput("lockOneGrant", 1, 0);
            if (CoreGnt) begin
                coreGnts++;
                coreAt   = hostIdx;
                coreWant = 1'b0;
            end
            if (HostGnt) begin
                hostIdx++;
                if (!coreSeen) coreWant = 1'b1;
                coreSeen = 1'b1;
            end
        end
        checkOutput("lockHostGnts", hostIdx, 20);
        checkOutput("lockCoreGnts", coreGnts, 1);
        checkOutput("lockCoreAt", coreAt, 16);
        checkOutput("lockCycles", cyc, 21);
        idleCycle();

        // Read back all 20 burst addresses, pipelined.
        for (int i = 0; i <= 20; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00,
                          (i < 20), 1'b0, 1'b0, 8'(i), 8'h00);
            if (i < 20) checkOutput($sformatf("rbGnt%0d", i), HostGnt, 1);
            if (i > 0) begin
                checkOutput($sformatf("rbRValid%0d", i - 1), HostRValid, 1);
                checkOutput($sformatf("rbRData%0d", i - 1), HostRData, 8'(8'h80 + i - 1));
            end
        end
        idleCycle();

        // Reset while locked with a host read in flight.
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
        checkOutput("mrHostGnt", HostGnt, 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
        checkOutput("mrRstRValid", HostRValid, 0);
        checkOutput("mrRstHostGnt", HostGnt, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        idleCycle();
        checkOutput("mrRelHostRValid", HostRValid, 0);
        checkOutput("mrRelCoreRValid", CoreRValid, 0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 1'b1, 8'h05, 8'h00);
        checkOutput("mrArbCoreGnt", CoreGnt, 1);
        checkOutput("mrArbHostGnt", HostGnt, 0);
        idleCycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
